lsu_mem_stage: RTL and testbench

//  Memory-stage load/store unit of the 5-stage RV32I pipeline. Consumes the
//  E/M register outputs (address, store data, Func3, MemWrite/MemRead) and runs
//  a req/ack transaction on the data-memory bus. Stalls the pipeline until the

---
 rtl/lsu_mem_stage_if.sv | 20 ++
 rtl/lsu_mem_stage.sv | 162 ++++++++++++++++
 tb/tb_lsu_mem_stage.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_stage_if.sv
// Data-memory request/acknowledge bus between the memory-stage LSU and the data memory.
interface lsu_mem_stage_if;
  logic        DmemReq;
  logic        DmemWe;
  logic [31:0] DmemAddr;
  logic [31:0] DmemWdata;
  logic [3:0]  DmemBe;
  logic        DmemAck;
  logic [31:0] DmemRdata;

  modport master (
    output DmemReq, DmemWe, DmemAddr, DmemWdata, DmemBe,
    input  DmemAck, DmemRdata
  );

  modport slave (
    input  DmemReq, DmemWe, DmemAddr, DmemWdata, DmemBe,
    output DmemAck, DmemRdata
  );
endinterface

// File: rtl/lsu_mem_stage.sv
// Memory-stage load/store unit: runs one req/ack data-memory transaction per access,
// stalls the pipeline meanwhile and returns extended load data.
module lsu_mem_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            ALUResultM,
  input  logic [31:0]            WriteDataM,
  input  logic [2:0]             Func3M,
  input  logic                   MemWriteM,
  input  logic                   MemReadM,
  lsu_mem_stage_if.master        dmem,
  output logic                   StallM,
  output logic [31:0]            ReadDataM,
  output logic                   LoadValidM,
  output logic                   FaultM
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t          state, state_next;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [3:0]      be_q;
  logic            we_q, fault_q;
  logic [2:0]      func3_q;
  logic [1:0]      lo_q;
  logic [CW-1:0]   cnt_q, cnt_inc;

  logic            access, illegal_f3, misaligned, bad, good, timeout_hit;
  logic [3:0]      be_calc;
  logic [31:0]     wdata_calc, lane, load_ext;

  // Access decode on the live E/M values.
  assign access     = MemReadM | MemWriteM;
  assign illegal_f3 = MemWriteM ? (Func3M > 3'b010)
                                : (Func3M == 3'b011 || Func3M[2:1] == 2'b11);
  assign misaligned = (Func3M[1:0] == 2'b01 && ALUResultM[0]) ||
                      (Func3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00);
  assign bad        = access && ((MemReadM && MemWriteM) || illegal_f3 || misaligned);
  assign good       = access && !bad;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = WriteDataM;
    case (Func3M[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << ALUResultM[1:0];
        wdata_calc = {4{WriteDataM[7:0]}};
      end
      2'b01: begin
        be_calc    = 4'b0011 << {ALUResultM[1], 1'b0};
        wdata_calc = {2{WriteDataM[15:0]}};
      end
      default: ;
    endcase
  end

  assign lane = dmem.DmemRdata >> {lo_q, 3'b000};

  always_comb begin
    load_ext = lane;
    case (func3_q)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'd0, lane[7:0]};
      3'b101:  load_ext = {16'd0, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_inc == CW'(TIMEOUT_CYCLES));

  always_comb begin
    state_next = state;
    StallM     = 1'b0;
    FaultM     = 1'b0;
    LoadValidM = 1'b0;
    case (state)
      IDLE: begin
        if (bad) begin
          FaultM = 1'b1;
        end else if (good) begin
          StallM     = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        StallM = 1'b1;
        // Ack is checked first so it wins over a coincident timeout.
        if (dmem.DmemAck || timeout_hit) state_next = DONE;
      end
      DONE: begin
        LoadValidM = !we_q && !fault_q;
        FaultM     = fault_q;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (reset) begin
      state_next = IDLE;
      StallM     = 1'b0;
      FaultM     = 1'b0;
      LoadValidM = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      fault_q <= 1'b0;
      func3_q <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (good) begin
            addr_q  <= {ALUResultM[31:2], 2'b00};
            wdata_q <= wdata_calc;
            be_q    <= be_calc;
            we_q    <= MemWriteM;
            func3_q <= Func3M;
            lo_q    <= ALUResultM[1:0];
            fault_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        REQ: begin
          if (dmem.DmemAck) begin
            if (!we_q) rdata_q <= load_ext;
          end else if (timeout_hit) begin
            fault_q <= 1'b1;
            rdata_q <= '0;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem.DmemReq   = (state == REQ);
  assign dmem.DmemWe    = we_q;
  assign dmem.DmemAddr  = addr_q;
  assign dmem.DmemWdata = wdata_q;
  assign dmem.DmemBe    = be_q;
  assign ReadDataM      = rdata_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: a cycle-stepped bus responder plus a queue of
// expected load results compared whenever LoadValidM fires.
module tb_lsu_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALUResultM, WriteDataM;
  logic [2:0]  Func3M;
  logic        MemWriteM, MemReadM;
  logic        StallM, LoadValidM, FaultM;
  logic [31:0] ReadDataM;

  lsu_mem_stage_if bus ();

  lsu_mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .Func3M     (Func3M),
    .MemWriteM  (MemWriteM),
    .MemReadM   (MemReadM),
    .dmem       (bus),
    .StallM     (StallM),
    .ReadDataM  (ReadDataM),
    .LoadValidM (LoadValidM),
    .FaultM     (FaultM)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] exp_q[$];

  int          n_stall, n_req, n_fault, n_valid, unstable;
  logic [31:0] b_addr, b_wdata;
  logic [3:0]  b_be;
  logic        b_we;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
  endtask

  // Presents one access, acks on REQ cycle index ack_after (-1 = never) and
  // records what the DUT did until StallM drops.
  task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rdata, input int ack_after,
                        input logic push, input logic [31:0] exp_rd);
    n_stall = 0; n_req = 0; n_fault = 0; n_valid = 0; unstable = 0;
    @(posedge clk); #1;
    MemReadM = rd; MemWriteM = wr; Func3M = f3; ALUResultM = addr; WriteDataM = wd;
    if (push) exp_q.push_back(exp_rd);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (StallM) n_stall++;
      if (FaultM) n_fault++;
      if (LoadValidM) begin
        n_valid++;
        check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("ReadDataM", ReadDataM, exp_q.pop_front());
      end
      if (bus.DmemReq) begin
        if (n_req == 0) begin
          b_addr = bus.DmemAddr; b_wdata = bus.DmemWdata; b_be = bus.DmemBe; b_we = bus.DmemWe;
        end else if (b_addr !== bus.DmemAddr || b_wdata !== bus.DmemWdata ||
                     b_be !== bus.DmemBe || b_we !== bus.DmemWe) begin
          unstable++;
        end
        n_req++;
        bus.DmemAck   = ((n_req - 1) == ack_after);
        bus.DmemRdata = rdata;
      end else begin
        bus.DmemAck = 1'b0;
      end
      if (!StallM) break;
    end
    bus.DmemAck = 1'b0;
    @(posedge clk); #1;
    MemReadM = 1'b0; MemWriteM = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    ALUResultM = '0; WriteDataM = '0; Func3M = '0; MemWriteM = 1'b0; MemReadM = 1'b0;
    bus.DmemAck = 1'b0; bus.DmemRdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_StallM",     32'(StallM),       32'd0);
    check("rst_DmemReq",    32'(bus.DmemReq),  32'd0);
    check("rst_LoadValid",  32'(LoadValidM),   32'd0);
    check("rst_FaultM",     32'(FaultM),       32'd0);
    check("rst_ReadDataM",  ReadDataM,         32'd0);
    check("rst_DmemBe",     32'(bus.DmemBe),   32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // LW 0x100, ack on third REQ cycle
    access(1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF);
    check("lw_stall",  n_stall,  4);
    check("lw_req",    n_req,    3);
    check("lw_valid",  n_valid,  1);
    check("lw_fault",  n_fault,  0);
    check("lw_addr",   b_addr,   32'h100);
    check("lw_be",     32'(b_be), 32'hF);
    check("lw_we",     32'(b_we), 0);
    check("lw_stable", unstable, 0);

    access(1, 0, 3'b000, 32'h103, 0, 32'h80FF_FFFF, 0, 1, 32'hFFFF_FF80);
    check("lb_stall", n_stall, 2);
    check("lb_valid", n_valid, 1);
    check("lb_be",    32'(b_be), 32'b1000);
    access(1, 0, 3'b100, 32'h103, 0, 32'h80FF_FFFF, 0, 1, 32'h0000_0080);
    check("lbu_stall", n_stall, 2);
    access(1, 0, 3'b001, 32'h102, 0, 32'h80FF_FFFF, 0, 1, 32'hFFFF_80FF);
    check("lh_be", 32'(b_be), 32'b1100);

    access(0, 1, 3'b001, 32'h202, 32'h1234_ABCD, 0, 1, 0, 0);
    check("sh_be",    32'(b_be), 32'b1100);
    check("sh_wdata", b_wdata,   32'hABCD_ABCD);
    check("sh_we",    32'(b_we), 1);
    check("sh_addr",  b_addr,    32'h200);
    check("sh_valid", n_valid,   0);
    check("sh_rdata_hold", ReadDataM, 32'hFFFF_80FF);
    access(0, 1, 3'b000, 32'h201, 32'h0000_00A5, 0, 0, 0, 0);
    check("sb_be",    32'(b_be), 32'b0010);
    check("sb_wdata", b_wdata,   32'hA5A5_A5A5);

    // Rejected accesses: fault in the presenting cycle, no bus activity, no stall
    access(1, 0, 3'b010, 32'h101, 0, 0, 0, 0, 0);
    check("lw_mis_fault", n_fault, 1);
    check("lw_mis_req",   n_req,   0);
    check("lw_mis_stall", n_stall, 0);
    access(1, 0, 3'b001, 32'h103, 0, 0, 0, 0, 0);
    check("lh_mis_fault", n_fault, 1);
    check("lh_mis_req",   n_req,   0);
    access(1, 0, 3'b011, 32'h100, 0, 0, 0, 0, 0);
    check("ld_ill_fault", n_fault, 1);
    access(0, 1, 3'b100, 32'h100, 0, 0, 0, 0, 0);
    check("st_ill_fault", n_fault, 1);
    access(1, 1, 3'b010, 32'h100, 0, 0, 0, 0, 0);
    check("both_fault", n_fault, 1);
    check("both_req",   n_req,   0);

    // Timeout after 4 REQ cycles with no ack
    access(1, 0, 3'b010, 32'h300, 0, 0, -1, 0, 0);
    check("to_req",   n_req,     4);
    check("to_stall", n_stall,   5);
    check("to_fault", n_fault,   1);
    check("to_valid", n_valid,   0);
    check("to_rdata", ReadDataM, 32'd0);

    // Ack in the same cycle the timeout would fire
    access(1, 0, 3'b101, 32'h302, 0, 32'h8001_0000, 3, 1, 32'h0000_8001);
    check("race_req",   n_req,   4);
    check("race_fault", n_fault, 0);
    check("race_valid", n_valid, 1);

    // Stray ack while idle is ignored
    @(posedge clk); #1;
    bus.DmemAck = 1'b1; bus.DmemRdata = 32'h1234_5678;
    @(negedge clk);
    check("stray_req", 32'(bus.DmemReq), 0);
    @(posedge clk); #1 bus.DmemAck = 1'b0;
    @(negedge clk);
    check("stray_valid", 32'(LoadValidM), 0);
    check("stray_rdata", ReadDataM, 32'h0000_8001);

    // Reset while a request is outstanding
    @(posedge clk); #1;
    MemReadM = 1'b1; Func3M = 3'b010; ALUResultM = 32'h100;
    @(negedge clk);
    @(negedge clk);
    check("mid_req_active", 32'(bus.DmemReq), 1);
    @(posedge clk); #1;
    reset = 1'b1; MemReadM = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_req",   32'(bus.DmemReq), 0);
    check("mid_rst_stall", 32'(StallM),      0);
    #4 reset = 1'b0;
    access(1, 0, 3'b010, 32'h104, 0, 32'h0BAD_F00D, 0, 1, 32'h0BAD_F00D);
    check("post_rst_stall", n_stall, 2);
    check("post_rst_valid", n_valid, 1);

    check("sb_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
